// File: rtl/complex_pkg.sv
// Shared types and helpers for the Precision/Complex blocks.
// Holds the complex operation encoding and the saturating truncation helper.
package complex_pkg;

    typedef enum logic [1:0] {
        CPLX_ADD,
        CPLX_SUB,
        CPLX_ADDCONJ,
        CPLX_ADDJ
    } cplx_op_t;

    // Widest component supported by sat_trunc, plus headroom for a sum
    localparam int CPLX_MAXW = 64;
    localparam int CPLX_SW   = CPLX_MAXW + 2;

    typedef logic signed [CPLX_SW-1:0] cplx_wide_t;

    // Clamp a sign-extended value into the signed w-bit range
    function automatic logic [CPLX_MAXW-1:0] sat_trunc(
        input cplx_wide_t value,
        input int         w
    );
        cplx_wide_t lim;
        cplx_wide_t r;
        lim = cplx_wide_t'(1) <<< (w - 1);
        if (value >= lim) begin
            r = lim - cplx_wide_t'(1);
        end else if (value < -lim) begin
            r = -lim;
        end else begin
            r = value;
        end
        return r[CPLX_MAXW-1:0];
    endfunction

endpackage

// File: rtl/complex_addsub_lane.sv
// One W-bit component path: extend, optional negate, add, wrap/saturate.
// COMPLEX_ADDSUB_SAT_EN selects saturation instead of wrap-around.
module complex_addsub_lane
    import complex_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s1_en,
    input  logic         s2_en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         neg,
    output logic [W-1:0] y,
    output logic         ovf
);

    logic signed [W:0]   a_d, a_q;
    logic signed [W:0]   b_d, b_q;
    logic signed [W:0]   b_ext;
    logic signed [W+1:0] sum;
    logic [W-1:0]        y_d, y_q;
    logic                ovf_d, ovf_q;

    // Stage 1: sign-extend operands, negate B at W+1 bits so -min is exact
    always_comb begin
        b_ext = {b[W-1], b};
        a_d   = a_q;
        b_d   = b_q;
        if (s1_en) begin
            a_d = {a[W-1], a};
            b_d = neg ? -b_ext : b_ext;
        end
    end

    // Stage 2: full-precision sum, range check, then reduce to W bits
    always_comb begin
        sum   = {a_q[W], a_q} + {b_q[W], b_q};
        y_d   = y_q;
        ovf_d = ovf_q;
        if (s2_en) begin
            ovf_d = (sum[W+1:W-1] != 3'b000) && (sum[W+1:W-1] != 3'b111);
`ifdef COMPLEX_ADDSUB_SAT_EN
            y_d = W'(sat_trunc(cplx_wide_t'(sum), W));
`else
            y_d = sum[W-1:0];
`endif
        end
    end

    // Stage registers, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            y_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            y_q   <= y_d;
            ovf_q <= ovf_d;
        end
    end

    assign y   = y_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/complex_addsub_pipe.sv
// Two-stage valid/ready complex add/sub/add-conj/add-j with overflow flag.
// Define COMPLEX_ADDSUB_SAT_EN to saturate components instead of wrapping.
module complex_addsub_pipe
    import complex_pkg::*;
#(
    parameter int BITS      = 16,
    parameter     PRECISION = "INT"
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] c,
    output logic            out_ovf
);

    localparam int W = BITS / 2;

    if (PRECISION != "INT" || (BITS % 2) != 0 || BITS < 4) begin : g_bad_cfg
        $error("complex_addsub_pipe: unsupported PRECISION/BITS");
    end

    cplx_op_t     op;
    logic [W-1:0] re_b, im_b;
    logic         re_neg, im_neg;
    logic         s1_valid_d, s1_valid_q;
    logic         s2_valid_d, s2_valid_q;
    logic         s1_adv, s2_adv;
    logic         in_fire, s1_en, s2_en;
    logic [W-1:0] re_y, im_y;
    logic         re_ovf, im_ovf;

    assign op = cplx_op_t'(in_op);

    // Form effective B': pick/swap parts and choose which lanes negate
    always_comb begin
        re_b   = b[BITS-1:W];
        im_b   = b[W-1:0];
        re_neg = 1'b0;
        im_neg = 1'b0;
        unique case (op)
            CPLX_ADD: begin
            end
            CPLX_SUB: begin
                re_neg = 1'b1;
                im_neg = 1'b1;
            end
            CPLX_ADDCONJ: begin
                im_neg = 1'b1;
            end
            CPLX_ADDJ: begin
                re_b   = b[W-1:0];
                im_b   = b[BITS-1:W];
                re_neg = 1'b1;
            end
        endcase
    end

    // Handshake: a stage advances when empty or its consumer takes it
    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        in_ready   = !rst && s1_adv;
        in_fire    = in_valid && in_ready;
        s1_en      = in_fire;
        s2_en      = s2_adv && s1_valid_q;
        s1_valid_d = s1_adv ? in_fire : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    end

    // Stage occupancy; reset drops anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    complex_addsub_lane #(.W(W)) u_re (
        .clk   (clk),
        .rst   (rst),
        .s1_en (s1_en),
        .s2_en (s2_en),
        .a     (a[BITS-1:W]),
        .b     (re_b),
        .neg   (re_neg),
        .y     (re_y),
        .ovf   (re_ovf)
    );

    complex_addsub_lane #(.W(W)) u_im (
        .clk   (clk),
        .rst   (rst),
        .s1_en (s1_en),
        .s2_en (s2_en),
        .a     (a[W-1:0]),
        .b     (im_b),
        .neg   (im_neg),
        .y     (im_y),
        .ovf   (im_ovf)
    );

    assign out_valid = s2_valid_q;
    assign c         = {re_y, im_y};
    assign out_ovf   = re_ovf | im_ovf;

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Bench for complex_addsub_pipe at BITS=16, reference model in plain ints.
// Honours COMPLEX_ADDSUB_SAT_EN the same way as the design build.
module tb_complex_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] c;
    logic        out_ovf;

    complex_addsub_pipe #(.BITS(16), .PRECISION("INT")) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        logic        ovf;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          t_now = 0;
    bit          lat_en = 0;
    bit          last_fire = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_c = '0;
    logic        prev_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Complex arithmetic on integers, then range check and fold to 8 bits
    function automatic void ref_op(input logic [15:0] ra, input logic [15:0] rb,
                                   input logic [1:0] op,
                                   output logic [15:0] rc, output logic rovf);
        int ar, ai, br, bi, xr, xi, cr, ci;
        ar = int'($signed(ra[15:8]));
        ai = int'($signed(ra[7:0]));
        br = int'($signed(rb[15:8]));
        bi = int'($signed(rb[7:0]));
        case (op)
            2'd0:    begin xr = br;  xi = bi;  end
            2'd1:    begin xr = -br; xi = -bi; end
            2'd2:    begin xr = br;  xi = -bi; end
            default: begin xr = -bi; xi = br;  end
        endcase
        cr = ar + xr;
        ci = ai + xi;
        rovf = (cr > 127) || (cr < -128) || (ci > 127) || (ci < -128);
`ifdef COMPLEX_ADDSUB_SAT_EN
        if (cr > 127) cr = 127; else if (cr < -128) cr = -128;
        if (ci > 127) ci = 127; else if (ci < -128) ci = -128;
`endif
        rc = {cr[7:0], ci[7:0]};
    endfunction

    // One cycle: drive at negedge, check outputs, update model for the edge
    task automatic step(input bit v, input logic [15:0] sa, input logic [15:0] sb,
                        input logic [1:0] sop, input bit ordy,
                        input bit ue, input logic [15:0] ec, input logic eo);
        exp_t e;
        logic [15:0] mc;
        logic        mo;
        int          sz;
        @(negedge clk);
        in_valid  = v;
        a         = sa;
        b         = sb;
        in_op     = sop;
        out_ready = ordy;
        #1;
        sz = q.size();
        if (prev_stall) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_c", {16'd0, c}, {16'd0, prev_c});
            chk("hold_ovf", {31'd0, out_ovf}, {31'd0, prev_ovf});
        end
        chk("in_ready", {31'd0, in_ready}, {31'd0, !(sz == 2 && !ordy)});
        if (out_valid) begin
            chk("valid_has_entry", {31'd0, sz != 0}, 32'd1);
            if (sz != 0 && ordy) begin
                e = q.pop_front();
                chk("c", {16'd0, c}, {16'd0, e.c});
                chk("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
                if (lat_en) chk("latency", t_now - e.t, 32'd2);
            end
        end
        last_fire = v && in_ready;
        if (last_fire) begin
            ref_op(sa, sb, sop, mc, mo);
            e.c   = ue ? ec : mc;
            e.ovf = ue ? eo : mo;
            e.t   = t_now;
            q.push_back(e);
        end
        prev_stall = out_valid && !ordy;
        prev_c     = c;
        prev_ovf   = out_ovf;
        t_now++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 2'd0, 1, 0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++)
            step(0, '0, '0, 2'd0, 1, 0, '0, 1'b0);
        chk("drained", q.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] da, db;
        logic [1:0]  dop;
        int          sent, guard, k;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_c", {16'd0, c}, 32'd0);
        chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;

        // Four ops back-to-back, fixed latency of two
        lat_en = 1;
        step(1, 16'h0305, 16'h01FE, 2'd0, 1, 1, 16'h0403, 1'b0);
        step(1, 16'h0305, 16'h01FE, 2'd1, 1, 1, 16'h0207, 1'b0);
        step(1, 16'h0305, 16'h01FE, 2'd2, 1, 1, 16'h0407, 1'b0);
        step(1, 16'h0305, 16'h01FE, 2'd3, 1, 1, 16'h0506, 1'b0);
        idle(2);
        chk("dir_drained", q.size(), 32'd0);

        // Overflow boundaries
`ifdef COMPLEX_ADDSUB_SAT_EN
        step(1, 16'h7F00, 16'h0100, 2'd0, 1, 1, 16'h7F00, 1'b1);
        step(1, 16'h0080, 16'h807F, 2'd1, 1, 1, 16'h7F80, 1'b1);
`else
        step(1, 16'h7F00, 16'h0100, 2'd0, 1, 1, 16'h8000, 1'b1);
        step(1, 16'h0080, 16'h807F, 2'd1, 1, 1, 16'h8001, 1'b1);
`endif
        idle(2);
        chk("ovf_drained", q.size(), 32'd0);
        lat_en = 0;

        // Ten inputs with out_ready toggling 1,0,0,...
        sent  = 0;
        guard = 0;
        k     = 0;
        da  = 16'($urandom);
        db  = 16'($urandom);
        dop = 2'($urandom_range(0, 3));
        while (sent < 10 && guard < 100) begin
            step(1, da, db, dop, (k % 3) == 0, 0, '0, 1'b0);
            k++;
            guard++;
            if (last_fire) begin
                sent++;
                da  = 16'($urandom);
                db  = 16'($urandom);
                dop = 2'($urandom_range(0, 3));
            end
        end
        chk("stream_sent", sent, 32'd10);
        drain();

        // Reset with two entries in flight
        step(1, 16'h1111, 16'h2222, 2'd0, 0, 0, '0, 1'b0);
        step(1, 16'h3333, 16'h0101, 2'd1, 0, 0, '0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_c", {16'd0, c}, 32'd0);
        chk("mid_rst_ovf", {31'd0, out_ovf}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        q.delete();
        prev_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        step(1, 16'h0102, 16'h0304, 2'd3, 1, 0, '0, 1'b0);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                 0, '0, 1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
